buzz_arbiter: RTL and testbench

Round arbiter that sits directly downstream of the player-controller stage. It consumes that stage's `playerInputFlag`, `firstPlayerFlag` and `switchInput`, and latches exactly one answer per buzz. It compares the latched answer against the CPU-supplied target hex value, locks out players who answer wrong for the rest of the round, and keeps saturating per-player scores. The CPU arms each round and reads back the result flags and scores.

---
 rtl/buzz_arbiter.sv | 174 +++++++++++++++++
 tb/tb_buzz_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzz_arbiter.sv
// Round arbiter: captures one buzz per round, judges it against the CPU target,
// locks out wrong answerers for the rest of the round and keeps saturating scores.
module buzz_arbiter #(
   parameter int SCORE_W        = 8,
   parameter int LOCKOUT_CYCLES = 25000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 playerInputFlag,
   input  logic [1:0]           firstPlayerFlag,
   input  logic [7:0]           switchInput,
   input  logic [7:0]           target,
   input  logic                 roundStart,
   input  logic                 scoreClear,
   output logic                 armed,
   output logic                 answerValid,
   output logic                 answerCorrect,
   output logic [1:0]           winner,
   output logic [7:0]           answer,
   output logic [3:0]           lockMask,
   output logic [4*SCORE_W-1:0] scores
);

   localparam int LOCK_LAST_I = (LOCKOUT_CYCLES > 1) ? LOCKOUT_CYCLES - 1 : 0;
   localparam int CNT_W       = (LOCK_LAST_I > 0) ? $clog2(LOCK_LAST_I + 1) : 1;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_LAST_I);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CHECK, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic               flag_q, flag_d, flag_q2;
   logic [1:0]         sel_q, sel_d;
   logic [7:0]         data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               won_q, won_d;
   logic               armed_q, armed_d;
   logic               answer_valid_q, answer_valid_d;
   logic               answer_correct_q, answer_correct_d;
   logic [1:0]         winner_q, winner_d;
   logic [7:0]         answer_q, answer_d;
   logic [3:0]         lock_mask_q, lock_mask_d;
   logic [SCORE_W-1:0] score_q [4];
   logic [SCORE_W-1:0] score_d [4];
   logic               rise;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
   endfunction

   assign rise = flag_q & ~flag_q2;

   always_comb begin
      state_d          = state_q;
      flag_d           = playerInputFlag;
      sel_d            = firstPlayerFlag;
      data_d           = switchInput;
      cnt_d            = cnt_q;
      won_d            = won_q;
      answer_valid_d   = 1'b0;
      answer_correct_d = answer_correct_q;
      winner_d         = winner_q;
      answer_d         = answer_q;
      lock_mask_d      = lock_mask_q;
      score_d          = score_q;

      case (state_q)
         S_IDLE: begin
            if (roundStart) begin
               state_d          = S_ARMED;
               lock_mask_d      = 4'b0000;
               answer_correct_d = 1'b0;
               cnt_d            = '0;
            end
         end
         S_ARMED: begin
            if (roundStart) begin
               lock_mask_d      = 4'b0000;
               answer_correct_d = 1'b0;
               cnt_d            = '0;
            end else if (rise && !lock_mask_q[sel_q]) begin
               answer_d = data_q;
               winner_d = sel_q;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            // roundStart is deliberately not looked at: the judgement always completes
            answer_valid_d   = 1'b1;
            answer_correct_d = (answer_q == target);
            state_d          = S_WAIT;
            cnt_d            = '0;
            if (answer_q == target) begin
               score_d[winner_q] = sat_inc(score_q[winner_q]);
               won_d             = 1'b1;
            end else begin
               lock_mask_d[winner_q] = 1'b1;
               won_d                 = 1'b0;
            end
         end
         S_WAIT: begin
            if (roundStart) begin
               state_d          = S_ARMED;
               lock_mask_d      = 4'b0000;
               answer_correct_d = 1'b0;
               cnt_d            = '0;
            end else begin
               if (cnt_q < LOCK_LAST) cnt_d = cnt_q + CNT_W'(1);
               if (!flag_q && (won_q || cnt_q >= LOCK_LAST)) begin
                  if (won_q || lock_mask_q == 4'b1111) begin
                     state_d     = S_IDLE;
                     lock_mask_d = 4'b0000;
                  end else begin
                     state_d = S_ARMED;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A clear coinciding with a CHECK increment takes priority
      if (scoreClear) begin
         for (int i = 0; i < 4; i++) score_d[i] = '0;
      end

      armed_d = (state_d == S_ARMED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         flag_q           <= 1'b0;
         flag_q2          <= 1'b0;
         sel_q            <= 2'b00;
         data_q           <= 8'h00;
         cnt_q            <= '0;
         won_q            <= 1'b0;
         armed_q          <= 1'b0;
         answer_valid_q   <= 1'b0;
         answer_correct_q <= 1'b0;
         winner_q         <= 2'b00;
         answer_q         <= 8'h00;
         lock_mask_q      <= 4'b0000;
         score_q          <= '{default: '0};
      end else begin
         state_q          <= state_d;
         flag_q           <= flag_d;
         flag_q2          <= flag_q;
         sel_q            <= sel_d;
         data_q           <= data_d;
         cnt_q            <= cnt_d;
         won_q            <= won_d;
         armed_q          <= armed_d;
         answer_valid_q   <= answer_valid_d;
         answer_correct_q <= answer_correct_d;
         winner_q         <= winner_d;
         answer_q         <= answer_d;
         lock_mask_q      <= lock_mask_d;
         score_q          <= score_d;
      end
   end

   assign armed         = armed_q;
   assign answerValid   = answer_valid_q;
   assign answerCorrect = answer_correct_q;
   assign winner        = winner_q;
   assign answer        = answer_q;
   assign lockMask      = lock_mask_q;

   for (genvar g = 0; g < 4; g++) begin : g_scores
      assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
   end

endmodule

// File: tb/tb_buzz_arbiter.sv
// Scoreboard bench for buzz_arbiter: stimulus queues expected judgements,
// a negedge monitor pops and compares them whenever answerValid is seen.
module tb_buzz_arbiter;

   localparam int SCORE_W = 2;
   localparam int LOCKOUT = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 playerInputFlag;
   logic [1:0]           firstPlayerFlag;
   logic [7:0]           switchInput;
   logic [7:0]           target;
   logic                 roundStart;
   logic                 scoreClear;
   logic                 armed;
   logic                 answerValid;
   logic                 answerCorrect;
   logic [1:0]           winner;
   logic [7:0]           answer;
   logic [3:0]           lockMask;
   logic [4*SCORE_W-1:0] scores;

   typedef struct {
      logic       correct;
      logic [1:0] winner;
      logic [7:0] answer;
      logic [3:0] lock;
      logic [7:0] scores;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic prev_av = 1'b0;

   buzz_arbiter #(.SCORE_W(SCORE_W), .LOCKOUT_CYCLES(LOCKOUT)) dut (
      .clk(clk), .reset(reset), .playerInputFlag(playerInputFlag),
      .firstPlayerFlag(firstPlayerFlag), .switchInput(switchInput), .target(target),
      .roundStart(roundStart), .scoreClear(scoreClear), .armed(armed),
      .answerValid(answerValid), .answerCorrect(answerCorrect), .winner(winner),
      .answer(answer), .lockMask(lockMask), .scores(scores)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: every answerValid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (answerValid) begin
         check("av_not_back_to_back", {31'b0, prev_av}, 32'd0);
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL av_unexpected: answerValid=1 with nothing expected (cycle %0d)", cyc);
         end else begin
            mon_e = q.pop_front();
            check("av_latency", cyc, mon_e.cyc);
            check("answerCorrect", {31'b0, answerCorrect}, {31'b0, mon_e.correct});
            check("winner", {30'b0, winner}, {30'b0, mon_e.winner});
            check("answer", {24'b0, answer}, {24'b0, mon_e.answer});
            check("lockMask", {28'b0, lockMask}, {28'b0, mon_e.lock});
            check("scores", {24'b0, scores}, {24'b0, mon_e.scores});
         end
      end
      prev_av <= answerValid;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_round(input logic [7:0] t);
      target     = t;
      roundStart = 1'b1;
      tick(1);
      roundStart = 1'b0;
   endtask

   task automatic start_press(input logic [1:0] p, input logic [7:0] sw, input bit cap,
                              input logic corr, input logic [3:0] lk, input logic [7:0] sc);
      exp_t e;
      playerInputFlag = 1'b1;
      firstPlayerFlag = p;
      switchInput     = sw;
      if (cap) begin
         e.correct = corr;
         e.winner  = p;
         e.answer  = sw;
         e.lock    = lk;
         e.scores  = sc;
         e.cyc     = cyc + 3;
         q.push_back(e);
      end
   endtask

   task automatic release_press();
      playerInputFlag = 1'b0;
      firstPlayerFlag = 2'b00;
      switchInput     = 8'h00;
   endtask

   initial begin
      logic [3:0] lk;
      logic [1:0] p4;
      reset = 1'b1;
      playerInputFlag = 1'b0;
      firstPlayerFlag = 2'b00;
      switchInput = 8'h00;
      target = 8'h00;
      roundStart = 1'b0;
      scoreClear = 1'b0;
      tick(3);
      check("rst_armed", {31'b0, armed}, 0);
      check("rst_answerValid", {31'b0, answerValid}, 0);
      check("rst_answerCorrect", {31'b0, answerCorrect}, 0);
      check("rst_winner", {30'b0, winner}, 0);
      check("rst_answer", {24'b0, answer}, 0);
      check("rst_lockMask", {28'b0, lockMask}, 0);
      check("rst_scores", {24'b0, scores}, 0);
      reset = 1'b0;
      tick(1);

      // Correct answer from p2
      pulse_round(8'h3C);
      check("t1_armed", {31'b0, armed}, 1);
      start_press(2'd1, 8'h3C, 1, 1'b1, 4'b0000, 8'h04);
      tick(4);
      release_press();
      tick(3);
      check("t1_idle_armed", {31'b0, armed}, 0);

      // Wrong answer from p1, lockout dwell, locked p1 ignored, p3 scores
      pulse_round(8'hA5);
      start_press(2'd0, 8'h11, 1, 1'b0, 4'b0001, 8'h04);
      tick(4);
      release_press();
      tick(6);
      check("t2_dwell_not_armed", {31'b0, armed}, 0);
      tick(1);
      check("t2_rearmed", {31'b0, armed}, 1);
      start_press(2'd0, 8'hA5, 0, 1'b0, 4'b0000, 8'h00);
      tick(4);
      release_press();
      tick(2);
      check("t2_locked_ignored", {31'b0, armed}, 1);
      start_press(2'd2, 8'hA5, 1, 1'b1, 4'b0001, 8'h14);
      tick(2);
      release_press();
      tick(3);
      check("t2_end_lockMask", {28'b0, lockMask}, 0);
      check("t2_end_armed", {31'b0, armed}, 0);

      // All four players wrong
      pulse_round(8'h77);
      lk = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         lk = lk | (4'b0001 << i);
         start_press(2'(i), 8'h10 + 8'(i), 1, 1'b0, lk, 8'h14);
         tick(2);
         release_press();
         tick(7);
         check("t3_wait_lockMask", {28'b0, lockMask}, {28'b0, lk});
         tick(2);
         if (i < 3) begin
            check("t3_rearmed", {31'b0, armed}, 1);
         end else begin
            check("t3_all_locked_idle", {31'b0, armed}, 0);
            check("t3_idle_lockMask", {28'b0, lockMask}, 0);
         end
      end

      // p4 saturates at 3 with a 2-bit score
      for (int k = 1; k <= 5; k++) begin
         p4 = (k > 3) ? 2'd3 : 2'(k);
         pulse_round(8'h5A);
         start_press(2'd3, 8'h5A, 1, 1'b1, 4'b0000, {p4, 6'b010100});
         tick(2);
         release_press();
         tick(3);
      end
      scoreClear = 1'b1;
      tick(1);
      scoreClear = 1'b0;
      check("t4_cleared", {24'b0, scores}, 0);

      // scoreClear coinciding with the CHECK increment wins
      pulse_round(8'h5A);
      start_press(2'd3, 8'h5A, 1, 1'b1, 4'b0000, 8'h00);
      tick(2);
      scoreClear = 1'b1;
      tick(1);
      scoreClear = 1'b0;
      release_press();
      tick(3);

      // Flag held across roundStart is never captured
      target = 8'h33;
      playerInputFlag = 1'b1;
      firstPlayerFlag = 2'd1;
      switchInput = 8'h33;
      tick(3);
      pulse_round(8'h33);
      tick(5);
      check("t5_held_no_capture", {31'b0, armed}, 1);
      release_press();
      tick(2);
      start_press(2'd1, 8'h33, 1, 1'b1, 4'b0000, 8'h04);
      tick(2);
      release_press();
      tick(3);

      // roundStart during CHECK is ignored
      pulse_round(8'h42);
      start_press(2'd0, 8'h42, 1, 1'b1, 4'b0000, 8'h05);
      tick(2);
      roundStart = 1'b1;
      tick(1);
      roundStart = 1'b0;
      check("t6_rs_in_check_ignored", {31'b0, armed}, 0);
      release_press();
      tick(3);

      // Reset during CHECK discards the pending judgement
      pulse_round(8'h42);
      start_press(2'd1, 8'h42, 0, 1'b0, 4'b0000, 8'h00);
      tick(2);
      reset = 1'b1;
      tick(1);
      check("t6_rst_answerValid", {31'b0, answerValid}, 0);
      check("t6_rst_answerCorrect", {31'b0, answerCorrect}, 0);
      check("t6_rst_winner", {30'b0, winner}, 0);
      check("t6_rst_answer", {24'b0, answer}, 0);
      check("t6_rst_scores", {24'b0, scores}, 0);
      check("t6_rst_armed", {31'b0, armed}, 0);
      reset = 1'b0;
      release_press();
      tick(2);

      // roundStart during WAIT restarts the round and clears the lockout
      pulse_round(8'h99);
      start_press(2'd2, 8'h00, 1, 1'b0, 4'b0100, 8'h00);
      tick(2);
      release_press();
      tick(1);
      roundStart = 1'b1;
      tick(1);
      roundStart = 1'b0;
      check("t7_restart_armed", {31'b0, armed}, 1);
      check("t7_restart_lockMask", {28'b0, lockMask}, 0);

      tick(5);
      check("pending_expectations", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
